hack_fetch_unit: RTL and testbench
==================================

Name: hack_fetch_unit

Overview:
- Instruction fetch stage of the Hack CPU; sits directly downstream of the instruction ROM.
- The ROM is synchronous: it samples a 15-bit address on posedge clk and presents 16-bit data after that edge.
- This block owns the program counter and drives the ROM address.
- It tags each returned word with its PC and hands it to decode/execute over a valid/ready interface.
- It absorbs stalls with a one-entry skid buffer and flushes on jumps.

Parameters:
ADDR_W, 15, ROM address / PC width
DATA_W, 16, instruction width
RESET_PC, 0, PC loaded on reset

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
rom_addr  out  ADDR_W  address to ROM; combinational copy of f_pc
rom_data  in  DATA_W  ROM data; valid the cycle after its address was presented
enable  in  1  fetch enable; low = issue no new addresses
jump_valid  in  1  redirect request, single-cycle
jump_target  in  ADDR_W  new PC when jump_valid
instr_valid  out  1  instr/instr_pc hold a valid instruction
instr_ready  in  1  consumer accepts instruction this cycle
instr  out  DATA_W  instruction word
instr_pc  out  ADDR_W  address the instruction was fetched from

Behaviour:
- Reset (async, rst_n=0):
  - f_pc=RESET_PC.
  - rq_valid=0, skid_valid=0, instr_valid=0.
  - instr=0, instr_pc=0, so rom_addr=RESET_PC.
- Issue condition: issue = enable & ~jump_valid & ~skid_valid & ~(rq_valid & instr_valid & ~instr_ready).
- On issue:
  - rq_valid<=1, rq_pc<=f_pc.
  - f_pc<=f_pc+1, modulo 2^ADDR_W; 32767 wraps to 0.
- No issue: rq_valid<=0; f_pc holds.
- Response: while rq_valid=1, rom_data is the word at rq_pc.
- Consume: cons = instr_valid & instr_ready.
- Output register priority, when not jumping:
  - (a) skid_valid & (~instr_valid | cons): output<=skid; skid_valid<=0, unless a response is also arriving, in which case skid<=response.
  - (b) else rq_valid & (~instr_valid | cons): output<=response.
  - (c) else rq_valid: skid<=response, skid_valid<=1.
  - (d) else if cons: instr_valid<=0.
- Invariants:
  - At most 3 words in flight (rq, skid, output).
  - No word is dropped or duplicated except by a jump.
  - Order is strictly ascending PC between jumps.
- Jump (jump_valid=1):
  - Highest priority.
  - rq_valid<=0, skid_valid<=0, instr_valid<=0; f_pc<=jump_target.
  - A simultaneous handshake counts as consumed by the consumer; the block discards without error.
- Latency:
  - Reset release or jump at edge E: target address issued at E+1.
  - Instruction visible with instr_valid=1 after E+2.
  - With instr_ready=1 held, one instruction per cycle thereafter.
- enable low: in-flight and skid words still drain to the output; no new issue. Raising enable resumes at the held f_pc.
- Reset mid-operation: all valids clear immediately (asynchronous); fetch restarts at RESET_PC after release.
- Output stability: instr/instr_pc remain stable while instr_valid=1 and instr_ready=0.
- Implicit state (for coverage): EMPTY (nothing valid), STREAM (output valid, skid empty), STALLED (output+skid valid), FLUSH (cycle after jump).

Decomposition:
- Shared package hack_pkg: ADDR_W/DATA_W constants, RESET_PC default, typedefs hack_addr_t (15b) and hack_word_t (16b).
- One natural sub-module: fetch_skid_buf, a one-entry data+pc skid register with flush.
- PC/issue logic and output register stay in the top.

Test Plan:
1. ROM model holds 0x0005,0xEC10,0x0005,0x0005,0x0005,0x0005,0xEC07 at 0..6; reset release, enable=1, ready=1 -> first instr_valid after 2nd edge. Sequence (pc,instr) must be (0,0x0005),(1,0xEC10),(2,0x0005)...(6,0xEC07) on consecutive cycles.
2. Stall: ready=0 for 4 cycles while instr_pc=2 -> output holds (2,0x0005), rom_addr stops advancing. Releasing gives pcs 3,4,5,6 back-to-back with no gap, loss or duplicate.
3. Jump: at instr_pc=3, assert jump_valid with jump_target=6 for 1 cycle -> instr_valid=0 for 2 cycles, then (6,0xEC07). pcs 4,5 are never presented.
4. Wrap: jump_target=32766 -> instr_pc 32766, 32767, 0, 1 in order.
5. enable: drop enable mid-stream -> at most 2 further instructions, then instr_valid=0. Re-enable resumes at the next sequential pc.
6. Reset: assert rst_n=0 asynchronously between edges while stalled -> instr_valid=0 immediately. After release, sequence restarts at (0,0x0005); jump asserted together with a stall edge also verified.

Source files
------------

// File: rtl/hack_pkg.sv
// Shared constants and types for the Hack CPU fetch path.
package hack_pkg;

    localparam int HACK_ADDR_W = 15;
    localparam int HACK_DATA_W = 16;

    typedef logic [HACK_ADDR_W-1:0] hack_addr_t;
    typedef logic [HACK_DATA_W-1:0] hack_word_t;

    localparam hack_addr_t HACK_RESET_PC = '0;

endpackage : hack_pkg

// File: rtl/fetch_skid_buf.sv
// One-entry skid register holding an instruction word and its PC.
// flush_i wins over load_i, which wins over clear_i.
module fetch_skid_buf
    import hack_pkg::*;
#(
    parameter int ADDR_W = HACK_ADDR_W,
    parameter int DATA_W = HACK_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [ADDR_W-1:0] pc_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [ADDR_W-1:0] pc_o
);

    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic [ADDR_W-1:0] pc_q;

    // Capture a word when loaded, drop it on flush or when it has been drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            pc_q    <= '0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
            pc_q    <= pc_i;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign pc_o    = pc_q;

endmodule : fetch_skid_buf

// File: rtl/hack_fetch_unit.sv
// Hack CPU instruction fetch: owns the PC, drives the synchronous ROM,
// tags returned words with their PC and hands them downstream over
// valid/ready. A one-entry skid absorbs the word already in flight when
// the consumer stalls; a jump flushes every stage and redirects the PC.
module hack_fetch_unit
    import hack_pkg::*;
#(
    parameter int                ADDR_W   = HACK_ADDR_W,
    parameter int                DATA_W   = HACK_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = HACK_RESET_PC
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    input  logic              enable,
    input  logic              jump_valid,
    input  logic [ADDR_W-1:0] jump_target,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc
);

    logic [ADDR_W-1:0] f_pc_q, f_pc_d;
    logic              rq_valid_q, rq_valid_d;
    logic [ADDR_W-1:0] rq_pc_q, rq_pc_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [ADDR_W-1:0] out_pc_q, out_pc_d;

    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic [ADDR_W-1:0] skid_pc;
    logic              skid_load;
    logic              skid_clear;

    logic              issue;
    logic              cons;
    logic              out_free;

    // Issue only when every word that could come back has a guaranteed slot.
    always_comb begin
        issue    = enable & ~jump_valid & ~skid_valid
                 & ~(rq_valid_q & out_valid_q & ~instr_ready);
        cons     = out_valid_q & instr_ready;
        out_free = ~out_valid_q | cons;

        rq_valid_d = issue;
        rq_pc_d    = issue ? f_pc_q : rq_pc_q;
        if (jump_valid) begin
            f_pc_d = jump_target;
        end else if (issue) begin
            f_pc_d = f_pc_q + 1'b1;
        end else begin
            f_pc_d = f_pc_q;
        end
    end

    // Output register refill: skid first (it is older), then the ROM response.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_pc_d    = out_pc_q;
        skid_load   = 1'b0;
        skid_clear  = 1'b0;

        if (jump_valid) begin
            out_valid_d = 1'b0;
        end else if (skid_valid && out_free) begin
            out_valid_d = 1'b1;
            out_data_d  = skid_data;
            out_pc_d    = skid_pc;
            if (rq_valid_q) begin
                skid_load = 1'b1;
            end else begin
                skid_clear = 1'b1;
            end
        end else if (rq_valid_q && out_free) begin
            out_valid_d = 1'b1;
            out_data_d  = rom_data;
            out_pc_d    = rq_pc_q;
        end else if (rq_valid_q) begin
            skid_load = 1'b1;
        end else if (cons) begin
            out_valid_d = 1'b0;
        end
    end

    // PC, outstanding-request and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_pc_q      <= RESET_PC;
            rq_valid_q  <= 1'b0;
            rq_pc_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_pc_q    <= '0;
        end else begin
            f_pc_q      <= f_pc_d;
            rq_valid_q  <= rq_valid_d;
            rq_pc_q     <= rq_pc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_pc_q    <= out_pc_d;
        end
    end

    fetch_skid_buf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (jump_valid),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .data_i  (rom_data),
        .pc_i    (rq_pc_q),
        .valid_o (skid_valid),
        .data_o  (skid_data),
        .pc_o    (skid_pc)
    );

    assign rom_addr    = f_pc_q;
    assign instr_valid = out_valid_q;
    assign instr       = out_data_q;
    assign instr_pc    = out_pc_q;

endmodule : hack_fetch_unit

// File: tb/tb_hack_fetch_unit.sv
// Bench for hack_fetch_unit: synchronous ROM model, directed scenarios and
// a randomized phase. The reference model is the stream contract: between
// redirects, accepted words carry consecutive PCs starting at the redirect
// target, each paired with the ROM word at that PC.
module tb_hack_fetch_unit;
    import hack_pkg::*;

    logic       clk;
    logic       rst_n;
    hack_addr_t rom_addr;
    hack_word_t rom_data;
    logic       enable;
    logic       jump_valid;
    hack_addr_t jump_target;
    logic       instr_valid;
    logic       instr_ready;
    hack_word_t instr;
    hack_addr_t instr_pc;

    int vectors     = 0;
    int miscompares = 0;

    hack_word_t mem [0:32767];
    hack_addr_t exp_pc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= mem[rom_addr];

    hack_fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .enable      (enable),
        .jump_valid  (jump_valid),
        .jump_target (jump_target),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Advance one clock; score any handshake at this edge against the model
    // and check the output held steady if it was stalled.
    task automatic step();
        logic       pv, pr, pj;
        hack_word_t pi;
        hack_addr_t pp;
        if (rst_n && instr_valid && instr_ready) begin
            chk("seq_pc", instr_pc, exp_pc);
            chk("seq_data", instr, mem[exp_pc]);
            $display("accept pc=%0d instr=%04h", instr_pc, instr);
            exp_pc = exp_pc + 1'b1;
        end
        if (rst_n && jump_valid) exp_pc = jump_target;
        pv = instr_valid; pr = instr_ready; pj = jump_valid;
        pi = instr; pp = instr_pc;
        @(posedge clk);
        #1;
        if (rst_n && pv && !pr && !pj) begin
            chk("hold_valid", instr_valid, 1);
            chk("hold_pc", instr_pc, pp);
            chk("hold_instr", instr, pi);
        end
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n = 0;
        while (!instr_valid && n < budget) begin
            step();
            n++;
        end
        chk(tag, instr_valid, 1);
    endtask

    task automatic jump_to(input hack_addr_t tgt, input string tag);
        jump_valid  = 1'b1;
        jump_target = tgt;
        step();
        jump_valid = 1'b0;
        chk({tag, "_flush0"}, instr_valid, 0);
        step();
        chk({tag, "_flush1"}, instr_valid, 0);
        step();
        chk({tag, "_valid"}, instr_valid, 1);
        chk({tag, "_pc"}, instr_pc, tgt);
        chk({tag, "_data"}, instr, mem[tgt]);
    endtask

    initial begin
        int cnt;
        hack_addr_t prog_pc;

        for (int i = 0; i < 32768; i++) mem[i] = hack_word_t'($urandom);
        mem[0] = 16'h0005; mem[1] = 16'hEC10; mem[2] = 16'h0005; mem[3] = 16'h0005;
        mem[4] = 16'h0005; mem[5] = 16'h0005; mem[6] = 16'hEC07;

        rst_n = 1'b1; enable = 1'b0; jump_valid = 1'b0; jump_target = '0; instr_ready = 1'b0;
        exp_pc = '0;
        #1 rst_n = 1'b0;
        enable = 1'b1;
        instr_ready = 1'b1;
        #2;
        chk("rst_valid", instr_valid, 0);
        chk("rst_addr", rom_addr, 0);
        chk("rst_instr", instr, 0);
        chk("rst_pc", instr_pc, 0);
        step();
        step();
        chk("rst_hold_valid", instr_valid, 0);

        // Reset release and streaming latency.
        rst_n  = 1'b1;
        exp_pc = '0;
        step();
        chk("t1_lat_valid", instr_valid, 0);
        chk("t1_lat_addr", rom_addr, 1);
        step();
        chk("t1_first_valid", instr_valid, 1);
        chk("t1_first_pc", instr_pc, 0);
        chk("t1_first_data", instr, 16'h0005);
        for (int k = 1; k <= 2; k++) begin
            step();
            chk("t1_stream_valid", instr_valid, 1);
            chk("t1_stream_pc", instr_pc, k);
        end

        // Stall at pc 2: output and ROM address freeze.
        instr_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t2_stall_pc", instr_pc, 2);
            chk("t2_stall_data", instr, 16'h0005);
            chk("t2_stall_addr", rom_addr, 4);
        end
        instr_ready = 1'b1;
        step();
        for (int p = 3; p <= 6; p++) begin
            wait_valid("t2_drain_valid", 3);
            chk("t2_drain_pc", instr_pc, p);
            step();
        end

        // Jump flush: back to 0, stream to pc 3, then redirect to 6.
        jump_to(15'd0, "t3_j0");
        for (int k = 0; k < 5 && !(instr_valid && instr_pc == 15'd3); k++) step();
        chk("t3_at_pc3", instr_pc, 3);
        jump_to(15'd6, "t3_j6");

        // PC wrap at the top of the address space.
        jump_to(15'd32766, "t4_wrap");
        prog_pc = 15'd32766;
        for (int k = 0; k < 3; k++) begin
            step();
            prog_pc = prog_pc + 1'b1;
            chk("t4_wrap_valid", instr_valid, 1);
            chk("t4_wrap_pc", instr_pc, prog_pc);
        end

        // Enable low drains what is in flight and then goes idle.
        enable = 1'b0;
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            if (instr_valid) cnt++;
            step();
        end
        chk("t5_drain_le2", cnt <= 2, 1);
        chk("t5_idle", instr_valid, 0);
        enable = 1'b1;
        wait_valid("t5_resume_valid", 4);
        chk("t5_resume_pc", instr_pc, exp_pc);

        // Asynchronous reset while stalled.
        instr_ready = 1'b0;
        for (int k = 0; k < 3; k++) step();
        #3 rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", instr_valid, 0);
        chk("t6_rst_addr", rom_addr, 0);
        step();
        rst_n = 1'b1;
        exp_pc = '0;
        instr_ready = 1'b1;
        step();
        chk("t6_lat_valid", instr_valid, 0);
        step();
        chk("t6_first_valid", instr_valid, 1);
        chk("t6_first_pc", instr_pc, 0);
        chk("t6_first_data", instr, 16'h0005);

        // Jump on an edge where the consumer is stalled.
        instr_ready = 1'b0;
        step();
        step();
        jump_to(15'd2, "t6_jstall");
        instr_ready = 1'b1;

        // Randomized traffic checked against the stream contract.
        for (int k = 0; k < 400; k++) begin
            enable      = ($urandom_range(0, 9) < 8);
            instr_ready = ($urandom_range(0, 9) < 6);
            jump_valid  = ($urandom_range(0, 19) == 0);
            jump_target = $urandom_range(0, 1) ? hack_addr_t'($urandom_range(0, 40))
                                               : hack_addr_t'(32767 - $urandom_range(0, 5));
            step();
            if (instr_valid) chk("rand_data", instr, mem[instr_pc]);
        end
        jump_valid  = 1'b0;
        enable      = 1'b1;
        instr_ready = 1'b1;
        wait_valid("final_live", 6);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_hack_fetch_unit
